countdown_ctrl: RTL and testbench

//  Sequencer for the seconds time base: countdown timer (MM:SS, 00:00..59:59) that gates and

---
 rtl/countdown_ctrl.sv | 144 ++++++++++++++
 tb/tb_countdown_ctrl.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/countdown_ctrl.sv
// MM:SS countdown sequencer: gates the seconds divider, consumes its divided clock
// as a tick and steps through IDLE/RUN/PAUSE/ALARM under push-button control.
module countdown_ctrl #(
  parameter int MAX_VAL     = 59,
  parameter int ALARM_TICKS = 5
) (
  input  logic       clkin,
  input  logic       rst,
  input  logic       tick_in,
  input  logic       btn_start,
  input  logic       btn_pause,
  input  logic       btn_clear,
  input  logic       load,
  input  logic [5:0] set_min,
  input  logic [5:0] set_sec,
  output logic       div_en,
  output logic       div_rst,
  output logic [7:0] min_bcd,
  output logic [7:0] sec_bcd,
  output logic [1:0] state,
  output logic       alarm,
  output logic       done
);

  typedef enum logic [1:0] {IDLE = 2'b00, RUN = 2'b01, PAUSE = 2'b10, ALARM = 2'b11} state_t;

  localparam int ACW = $clog2(ALARM_TICKS + 1);
  localparam logic [5:0] MAXV = 6'(MAX_VAL);

  state_t           cur;
  logic   [5:0]     min_cnt, sec_cnt;
  logic   [5:0]     dec_min, dec_sec;
  logic             tick_d, tick, dec_zero, count_zero;
  logic   [ACW-1:0] alarm_cnt, alarm_nxt;

  assign tick       = tick_in & ~tick_d;
  assign count_zero = (min_cnt == 6'd0) && (sec_cnt == 6'd0);
  assign alarm_nxt  = alarm_cnt + ACW'(1);

  // Borrow from minutes when seconds are exhausted; never wraps below 00:00.
  always_comb begin
    dec_min = min_cnt;
    dec_sec = sec_cnt;
    if (sec_cnt != 6'd0) begin
      dec_sec = sec_cnt - 6'd1;
    end else if (min_cnt != 6'd0) begin
      dec_sec = MAXV;
      dec_min = min_cnt - 6'd1;
    end
  end
  assign dec_zero = (dec_min == 6'd0) && (dec_sec == 6'd0);

  always_ff @(posedge clkin) begin
    if (rst) begin
      cur       <= IDLE;
      min_cnt   <= 6'd0;
      sec_cnt   <= 6'd0;
      tick_d    <= 1'b0;
      alarm_cnt <= '0;
      done      <= 1'b0;
    end else begin
      tick_d <= tick_in;
      done   <= 1'b0;
      unique case (cur)
        IDLE: begin
          if (btn_clear) begin
            min_cnt <= 6'd0;
            sec_cnt <= 6'd0;
          end else if (load) begin
            min_cnt <= (set_min > MAXV) ? MAXV : set_min;
            sec_cnt <= (set_sec > MAXV) ? MAXV : set_sec;
          end else if (btn_start && !count_zero) begin
            cur <= RUN;
          end
        end
        RUN: begin
          if (btn_clear) begin
            cur     <= IDLE;
            min_cnt <= 6'd0;
            sec_cnt <= 6'd0;
          end else begin
            // A tick coincident with pause still counts, and reaching zero beats pause.
            if (tick) begin
              min_cnt <= dec_min;
              sec_cnt <= dec_sec;
            end
            if (tick && dec_zero) begin
              cur       <= ALARM;
              done      <= 1'b1;
              alarm_cnt <= '0;
            end else if (btn_pause) begin
              cur <= PAUSE;
            end
          end
        end
        PAUSE: begin
          if (btn_clear) begin
            cur     <= IDLE;
            min_cnt <= 6'd0;
            sec_cnt <= 6'd0;
          end else if (!btn_pause && btn_start) begin
            cur <= RUN;
          end
        end
        ALARM: begin
          if (btn_clear || btn_pause || btn_start) begin
            cur       <= IDLE;
            alarm_cnt <= '0;
          end else if (tick) begin
            if (alarm_nxt == ACW'(ALARM_TICKS)) begin
              cur       <= IDLE;
              alarm_cnt <= '0;
            end else begin
              alarm_cnt <= alarm_nxt;
            end
          end
        end
        default: cur <= IDLE;
      endcase
    end
  end

  function automatic logic [7:0] to_bcd(input logic [5:0] v);
    logic [3:0] tens;
    logic [5:0] units;
    tens  = 4'd0;
    units = v;
    for (int i = 0; i < 5; i++) begin
      if (units >= 6'd10) begin
        units = units - 6'd10;
        tens  = tens + 4'd1;
      end
    end
    return {tens, units[3:0]};
  endfunction

  assign min_bcd = to_bcd(min_cnt);
  assign sec_bcd = to_bcd(sec_cnt);
  assign state   = cur;
  assign alarm   = (cur == ALARM);
  assign div_en  = (cur == RUN) || (cur == ALARM);
  assign div_rst = (cur == IDLE);

endmodule

// File: tb/tb_countdown_ctrl.sv
// Directed bench for countdown_ctrl: drives inputs on the falling edge and checks
// outputs on the following falling edge against hand-computed values.
module tb_countdown_ctrl;

  logic       clkin = 1'b0;
  logic       rst = 1'b1;
  logic       tick_in = 1'b0;
  logic       btn_start = 1'b0, btn_pause = 1'b0, btn_clear = 1'b0, load = 1'b0;
  logic [5:0] set_min = 6'd0, set_sec = 6'd0;
  logic       div_en, div_rst, alarm, done;
  logic [7:0] min_bcd, sec_bcd;
  logic [1:0] state;

  int checks = 0;
  int failures = 0;

  countdown_ctrl #(.MAX_VAL(59), .ALARM_TICKS(5)) dut (
    .clkin(clkin), .rst(rst), .tick_in(tick_in),
    .btn_start(btn_start), .btn_pause(btn_pause), .btn_clear(btn_clear),
    .load(load), .set_min(set_min), .set_sec(set_sec),
    .div_en(div_en), .div_rst(div_rst), .min_bcd(min_bcd), .sec_bcd(sec_bcd),
    .state(state), .alarm(alarm), .done(done)
  );

  always #5 clkin = ~clkin;

  task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", tag, act, exp);
    end
  endtask

  // Holds the given inputs for exactly one rising edge, returning on the next falling edge.
  task automatic applyStimulus(input logic s, input logic p, input logic c,
                               input logic l, input logic t);
    @(negedge clkin);
    btn_start = s; btn_pause = p; btn_clear = c; load = l; tick_in = t;
    @(negedge clkin);
    btn_start = 0; btn_pause = 0; btn_clear = 0; load = 0; tick_in = 0;
  endtask

  task automatic loadTime(input logic [5:0] m, input logic [5:0] s);
    set_min = m;
    set_sec = s;
    applyStimulus(0, 0, 0, 1, 0);
  endtask

  task automatic tickOnce();
    applyStimulus(0, 0, 0, 0, 1);
  endtask

  logic [7:0] exp_sec [6] = '{8'h04, 8'h03, 8'h02, 8'h01, 8'h00, 8'h59};
  logic [7:0] exp_min [6] = '{8'h01, 8'h01, 8'h01, 8'h01, 8'h01, 8'h00};

  initial begin
    // Reset held for three cycles
    repeat (3) @(negedge clkin);
    rst = 1'b0;
    @(negedge clkin);
    checkOutput("rst_state", 32'(state), 32'h0);
    checkOutput("rst_div_rst", 32'(div_rst), 32'h1);
    checkOutput("rst_div_en", 32'(div_en), 32'h0);
    checkOutput("rst_min", 32'(min_bcd), 32'h00);
    checkOutput("rst_sec", 32'(sec_bcd), 32'h00);
    checkOutput("rst_alarm", 32'(alarm), 32'h0);
    checkOutput("rst_done", 32'(done), 32'h0);

    // Countdown across a minute boundary
    loadTime(6'd1, 6'd5);
    checkOutput("load_min", 32'(min_bcd), 32'h01);
    checkOutput("load_sec", 32'(sec_bcd), 32'h05);
    applyStimulus(1, 0, 0, 0, 0);
    checkOutput("run_state", 32'(state), 32'h1);
    checkOutput("run_div_en", 32'(div_en), 32'h1);
    checkOutput("run_div_rst", 32'(div_rst), 32'h0);
    for (int i = 0; i < 6; i++) begin
      tickOnce();
      checkOutput($sformatf("dec%0d_sec", i), 32'(sec_bcd), 32'(exp_sec[i]));
      checkOutput($sformatf("dec%0d_min", i), 32'(min_bcd), 32'(exp_min[i]));
    end
    applyStimulus(0, 0, 1, 0, 0);

    // Reaching zero enters ALARM for five ticks
    loadTime(6'd0, 6'd2);
    applyStimulus(1, 0, 0, 0, 0);
    tickOnce();
    checkOutput("a_pre_state", 32'(state), 32'h1);
    checkOutput("a_pre_done", 32'(done), 32'h0);
    tickOnce();
    checkOutput("a_done_pulse", 32'(done), 32'h1);
    checkOutput("a_state", 32'(state), 32'h3);
    checkOutput("a_alarm", 32'(alarm), 32'h1);
    checkOutput("a_div_en", 32'(div_en), 32'h1);
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("a_done_low", 32'(done), 32'h0);
    checkOutput("a_hold_alarm", 32'(alarm), 32'h1);
    checkOutput("a_hold_sec", 32'(sec_bcd), 32'h00);
    for (int i = 0; i < 4; i++) tickOnce();
    checkOutput("a_tick4_state", 32'(state), 32'h3);
    tickOnce();
    checkOutput("a_end_state", 32'(state), 32'h0);
    checkOutput("a_end_alarm", 32'(alarm), 32'h0);
    checkOutput("a_end_div_rst", 32'(div_rst), 32'h1);

    // Pause freezes the count and keeps the divider out of reset
    loadTime(6'd0, 6'd10);
    applyStimulus(1, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) tickOnce();
    checkOutput("p_pre_sec", 32'(sec_bcd), 32'h07);
    applyStimulus(0, 1, 0, 0, 0);
    checkOutput("p_state", 32'(state), 32'h2);
    checkOutput("p_div_rst", 32'(div_rst), 32'h0);
    checkOutput("p_div_en", 32'(div_en), 32'h0);
    for (int i = 0; i < 4; i++) tickOnce();
    checkOutput("p_frozen_sec", 32'(sec_bcd), 32'h07);
    applyStimulus(1, 0, 0, 0, 0);
    checkOutput("p_resume_state", 32'(state), 32'h1);
    checkOutput("p_resume_sec", 32'(sec_bcd), 32'h07);
    tickOnce();
    checkOutput("p_after_sec", 32'(sec_bcd), 32'h06);
    checkOutput("p_after_min", 32'(min_bcd), 32'h00);

    // Clear coincident with a tick drops the tick
    applyStimulus(0, 0, 1, 0, 0);
    loadTime(6'd0, 6'd5);
    applyStimulus(1, 0, 0, 0, 0);
    applyStimulus(0, 0, 1, 0, 1);
    checkOutput("c_state", 32'(state), 32'h0);
    checkOutput("c_sec", 32'(sec_bcd), 32'h00);
    checkOutput("c_min", 32'(min_bcd), 32'h00);
    // Out-of-range loads saturate at 59
    loadTime(6'd63, 6'd60);
    checkOutput("sat_min", 32'(min_bcd), 32'h59);
    checkOutput("sat_sec", 32'(sec_bcd), 32'h59);
    set_min = 6'd2; set_sec = 6'd3;
    applyStimulus(1, 0, 0, 1, 0);
    checkOutput("ldst_state", 32'(state), 32'h0);
    checkOutput("ldst_sec", 32'(sec_bcd), 32'h03);
    applyStimulus(0, 0, 1, 0, 0);
    applyStimulus(1, 0, 0, 0, 0);
    checkOutput("zero_start", 32'(state), 32'h0);

    // Pause coincident with the final tick: ALARM wins
    loadTime(6'd0, 6'd1);
    applyStimulus(1, 0, 0, 0, 0);
    applyStimulus(0, 1, 0, 0, 1);
    checkOutput("pz_state", 32'(state), 32'h3);
    checkOutput("pz_done", 32'(done), 32'h1);
    applyStimulus(0, 0, 1, 0, 0);
    checkOutput("pz_exit", 32'(state), 32'h0);

    // Reset mid-RUN coincident with a tick
    loadTime(6'd0, 6'd30);
    applyStimulus(1, 0, 0, 0, 0);
    @(negedge clkin);
    rst = 1'b1; tick_in = 1'b1;
    @(negedge clkin);
    rst = 1'b0; tick_in = 1'b0;
    checkOutput("mr_state", 32'(state), 32'h0);
    checkOutput("mr_sec", 32'(sec_bcd), 32'h00);
    checkOutput("mr_min", 32'(min_bcd), 32'h00);
    checkOutput("mr_div_rst", 32'(div_rst), 32'h1);
    checkOutput("mr_div_en", 32'(div_en), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
